// File: rtl/dmem_responder_pkg.sv
// Shared command encodings, MMIO map and STATUS layout for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'h0,
        MEM_LB   = 4'h1,
        MEM_LH   = 4'h2,
        MEM_LW   = 4'h3,
        MEM_LBU  = 4'h4,
        MEM_LHU  = 4'h5,
        MEM_SB   = 4'h8,
        MEM_SH   = 4'h9,
        MEM_SW   = 4'hA
    } mem_cmd_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      load;
        logic      store;
        logic      uns;
        mem_size_e size;
    } mem_op_t;

    localparam logic [31:0] ADDR_CON_TX = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF08;

    localparam int ST_MIS = 6;
    localparam int ST_BAD = 7;
    localparam int ST_OVF = 8;

    function automatic mem_op_t decode_cmd(input logic [3:0] cmd);
        mem_op_t op;
        op = '{load: 1'b0, store: 1'b0, uns: 1'b0, size: SZ_W};
        case (cmd)
            MEM_LB:  op = '{load: 1'b1, store: 1'b0, uns: 1'b0, size: SZ_B};
            MEM_LH:  op = '{load: 1'b1, store: 1'b0, uns: 1'b0, size: SZ_H};
            MEM_LW:  op = '{load: 1'b1, store: 1'b0, uns: 1'b0, size: SZ_W};
            MEM_LBU: op = '{load: 1'b1, store: 1'b0, uns: 1'b1, size: SZ_B};
            MEM_LHU: op = '{load: 1'b1, store: 1'b0, uns: 1'b1, size: SZ_H};
            MEM_SB:  op = '{load: 1'b0, store: 1'b1, uns: 1'b0, size: SZ_B};
            MEM_SH:  op = '{load: 1'b0, store: 1'b1, uns: 1'b0, size: SZ_H};
            MEM_SW:  op = '{load: 1'b0, store: 1'b1, uns: 1'b0, size: SZ_W};
            default: op = '{load: 1'b0, store: 1'b0, uns: 1'b0, size: SZ_W};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bus plus console drain and error reporting.
interface dmem_responder_if;
    logic [31:0] MEM_mem_addr;
    logic [3:0]  MEM_mem_cmd;
    logic [31:0] MEM_mem_din;
    logic [31:0] DM_mem_dout;
    logic [7:0]  con_data;
    logic        con_vld;
    logic        con_rdy;
    logic        err_flag;
    logic [31:0] err_addr;

    modport slave (
        input  MEM_mem_addr, MEM_mem_cmd, MEM_mem_din, con_rdy,
        output DM_mem_dout, con_data, con_vld, err_flag, err_addr
    );

    modport master (
        output MEM_mem_addr, MEM_mem_cmd, MEM_mem_din, con_rdy,
        input  DM_mem_dout, con_data, con_vld, err_flag, err_addr
    );
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Console TX FIFO; head byte and non-empty come straight from registered state.
module dmem_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    output logic                     full,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM, console FIFO, STATUS and CYCLE registers.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    localparam int RW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   addr, din, word, wdata, ld_ram, ld_mmio, status, cyc;
    logic [RW-1:0] idx;
    logic [3:0]    be;
    logic [2:0]    sticky, set, clr;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [FW:0]   count;
    mem_op_t       op;
    logic          active, misal, in_ram, is_con, is_st, is_cyc, is_mmio;
    logic          set_mis, set_bad, ok, push, pop, full, empty;

    assign addr    = bus.MEM_mem_addr;
    assign din     = bus.MEM_mem_din;
    assign op      = decode_cmd(bus.MEM_mem_cmd);
    assign idx     = addr[RW+1:2];
    assign word    = ram[idx];
    assign active  = op.load | op.store;
    assign in_ram  = addr < RAM_BYTES;
    assign is_con  = addr == ADDR_CON_TX;
    assign is_st   = addr == ADDR_STATUS;
    assign is_cyc  = addr == ADDR_CYCLE;
    assign is_mmio = is_con | is_st | is_cyc;

    assign misal   = (op.size == SZ_H && addr[0]) ||
                     (op.size == SZ_W && addr[1:0] != 2'b00);
    assign set_mis = active & misal;
    assign set_bad = active & ~misal &
                     (~(in_ram | is_mmio) |
                      (is_mmio & (op.size != SZ_W)) |
                      (is_cyc & op.store));
    assign ok      = active & ~misal & ~set_bad;

    assign push    = ok & op.store & is_con;
    assign pop     = bus.con_vld & bus.con_rdy;
    assign clr     = (ok & op.store & is_st) ? din[ST_OVF:ST_MIS] : 3'b000;
    assign set     = {push & full & ~pop, set_bad, set_mis};

    dmem_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din[7:0]),
        .full  (full),
        .pop   (pop),
        .dout  (bus.con_data),
        .empty (empty),
        .count (count)
    );

    assign bus.con_vld  = ~empty;
    assign bus.err_flag = |sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky       <= '0;
            bus.err_addr <= '0;
            cyc          <= '0;
        end else begin
            sticky <= (sticky & ~clr) | set;
            if (|set && !bus.err_flag) bus.err_addr <= addr;
            cyc <= cyc + 32'd1;
        end
    end

    always_comb begin
        be    = 4'b0000;
        wdata = din;
        case (op.size)
            SZ_B: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
            end
            SZ_H: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && ok && op.store && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rbyte = word[{addr[1:0], 3'b000} +: 8];
    assign rhalf = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_ram = word;
        case (op.size)
            SZ_B:    ld_ram = op.uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            SZ_H:    ld_ram = op.uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: ld_ram = word;
        endcase
    end

    assign status  = {23'h0, sticky, full, empty, 4'(count)};
    assign ld_mmio = is_st ? status : (is_cyc ? cyc : 32'h0);

    assign bus.DM_mem_dout = (ok & op.load) ? (in_ram ? ld_ram : ld_mmio) : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector table plus hand-written FIFO, error and reset sequences.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    dmem_responder_if bus ();

    dmem_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] din);
        bus.MEM_mem_cmd  = cmd;
        bus.MEM_mem_addr = addr;
        bus.MEM_mem_din  = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    initial begin
        rst = 1'b1;
        bus.con_rdy = 1'b0;
        drive(MEM_NONE, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        drive(MEM_LW, ADDR_STATUS, 32'h0);
        mid();
        chk("rst_status", bus.DM_mem_dout, 32'h10);
        chk("rst_vld", 32'(bus.con_vld), 32'h0);
        chk("rst_data", 32'(bus.con_data), 32'h0);
        chk("rst_errf", 32'(bus.err_flag), 32'h0);
        chk("rst_erra", bus.err_addr, 32'h0);
        tick();

        vt.push_back('{MEM_SW,  32'h10, 32'hDEADBEEF, 32'h0});
        vt.push_back('{MEM_LB,  32'h13, 32'h0, 32'hFFFFFFDE});
        vt.push_back('{MEM_LBU, 32'h13, 32'h0, 32'h000000DE});
        vt.push_back('{MEM_LH,  32'h10, 32'h0, 32'hFFFFBEEF});
        vt.push_back('{MEM_LW,  32'h10, 32'h0, 32'hDEADBEEF});
        vt.push_back('{MEM_LHU, 32'h12, 32'h0, 32'h0000DEAD});
        vt.push_back('{MEM_LH,  32'h12, 32'h0, 32'hFFFFDEAD});
        vt.push_back('{MEM_LB,  32'h10, 32'h0, 32'hFFFFFFEF});
        vt.push_back('{MEM_LBU, 32'h11, 32'h0, 32'h000000BE});
        vt.push_back('{MEM_SW,  32'h20, 32'h0, 32'h0});
        vt.push_back('{MEM_SB,  32'h21, 32'h55, 32'h0});
        vt.push_back('{MEM_LW,  32'h20, 32'h0, 32'h00005500});
        vt.push_back('{MEM_SB,  32'h22, 32'h123456AB, 32'h0});
        vt.push_back('{MEM_LW,  32'h20, 32'h0, 32'h00AB5500});
        vt.push_back('{MEM_SW,  32'h24, 32'h0, 32'h0});
        vt.push_back('{MEM_SH,  32'h26, 32'h8001, 32'h0});
        vt.push_back('{MEM_LW,  32'h24, 32'h0, 32'h80010000});
        vt.push_back('{MEM_LB,  32'h27, 32'h0, 32'hFFFFFF80});
        vt.push_back('{MEM_LBU, 32'h26, 32'h0, 32'h00000001});
        vt.push_back('{4'h6,    32'h10, 32'h0, 32'h0});
        vt.push_back('{4'hF,    32'h10, 32'h0, 32'h0});
        vt.push_back('{MEM_LW,  ADDR_CON_TX, 32'h0, 32'h0});

        foreach (vt[i]) begin
            drive(vt[i].cmd, vt[i].addr, vt[i].din);
            mid();
            chk($sformatf("vec%0d", i), bus.DM_mem_dout, vt[i].exp);
            tick();
        end
        drive(MEM_NONE, 32'h0, 32'h0);
        mid();
        chk("vec_noerr", 32'(bus.err_flag), 32'h0);
        tick();

        drive(MEM_LW, 32'h6, 32'h0);
        mid();
        chk("mis_dout", bus.DM_mem_dout, 32'h0);
        tick();
        drive(MEM_LW, ADDR_STATUS, 32'h0);
        mid();
        chk("mis_status", bus.DM_mem_dout, 32'h50);
        chk("mis_erra", bus.err_addr, 32'h6);
        chk("mis_errf", 32'(bus.err_flag), 32'h1);
        tick();
        drive(MEM_SH, 32'h9, 32'h1234);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0);
        mid();
        chk("mis2_erra", bus.err_addr, 32'h6);
        tick();
        drive(MEM_SW, ADDR_STATUS, 32'h1C0);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0);
        mid();
        chk("clr_errf", 32'(bus.err_flag), 32'h0);
        tick();

        drive(MEM_SW, 32'h1000, 32'h1);
        tick();
        drive(MEM_LW, ADDR_STATUS, 32'h0);
        mid();
        chk("bad_status", bus.DM_mem_dout, 32'h90);
        chk("bad_erra", bus.err_addr, 32'h1000);
        tick();
        drive(MEM_LB, ADDR_CYCLE, 32'h0);
        mid();
        chk("bad_mmio_byte", bus.DM_mem_dout, 32'h0);
        tick();
        drive(MEM_SW, ADDR_STATUS, 32'h1C0);
        tick();

        bus.con_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(MEM_SW, ADDR_CON_TX, 32'h41 + i);
            tick();
        end
        drive(MEM_LW, ADDR_STATUS, 32'h0);
        mid();
        chk("ovf_status", bus.DM_mem_dout, 32'h128);
        chk("ovf_erra", bus.err_addr, ADDR_CON_TX);
        chk("ovf_head", 32'(bus.con_data), 32'h41);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0);
        bus.con_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk($sformatf("drain%0d_vld", i), 32'(bus.con_vld), 32'h1);
            chk($sformatf("drain%0d_data", i), 32'(bus.con_data), 32'h41 + i);
            tick();
        end
        mid();
        chk("drain_empty", 32'(bus.con_vld), 32'h0);
        bus.con_rdy = 1'b0;
        tick();

        drive(MEM_SW, ADDR_STATUS, 32'h100);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(MEM_SW, ADDR_CON_TX, 32'h60 + i);
            tick();
        end
        drive(MEM_SW, ADDR_CON_TX, 32'h5A);
        bus.con_rdy = 1'b1;
        mid();
        chk("pp_head", 32'(bus.con_data), 32'h60);
        tick();
        bus.con_rdy = 1'b0;
        drive(MEM_LW, ADDR_STATUS, 32'h0);
        mid();
        chk("pp_status", bus.DM_mem_dout, 32'h28);
        chk("pp_next", 32'(bus.con_data), 32'h61);
        tick();

        drive(MEM_NONE, 32'h0, 32'h0);
        bus.con_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("rdrain%0d", i), 32'(bus.con_data), 32'h61 + i);
            tick();
        end
        rst = 1'b1;
        drive(MEM_SW, 32'h10, 32'h11111111);
        tick();
        rst = 1'b0;
        drive(MEM_LW, ADDR_CYCLE, 32'h0);
        mid();
        chk("rrst_cycle", bus.DM_mem_dout, 32'h0);
        chk("rrst_vld", 32'(bus.con_vld), 32'h0);
        chk("rrst_data", 32'(bus.con_data), 32'h0);
        tick();
        bus.con_rdy = 1'b0;
        drive(MEM_LW, 32'h10, 32'h0);
        mid();
        chk("rrst_nostore", bus.DM_mem_dout, 32'hDEADBEEF);
        tick();
        drive(MEM_NONE, 32'h0, 32'h0);
        repeat (98) tick();
        drive(MEM_LW, ADDR_CYCLE, 32'h0);
        mid();
        chk("cycle100", bus.DM_mem_dout, 32'd100);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
